// File: rtl/alu_8bit_pkg.sv
// alu_8bit_pkg
//   Opcode constants and fixed result values shared by the ALU datapath
//   and its register wrapper.
package alu_8bit_pkg;

    // Arithmetic
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_INC  = 5'b00101;
    localparam logic [4:0] OP_DEC  = 5'b00110;
    // Bitwise logic
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b01001;
    localparam logic [4:0] OP_NAND = 5'b01010;
    localparam logic [4:0] OP_NOR  = 5'b01011;
    localparam logic [4:0] OP_XNOR = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;
    // Shift / rotate
    localparam logic [4:0] OP_SHL  = 5'b01110;
    localparam logic [4:0] OP_SHR  = 5'b01111;
    localparam logic [4:0] OP_ROL  = 5'b10000;
    localparam logic [4:0] OP_ROR  = 5'b10001;
    localparam logic [4:0] OP_NEG  = 5'b10010;
    // Compare / select
    localparam logic [4:0] OP_GT   = 5'b10011;
    localparam logic [4:0] OP_EQ   = 5'b10100;
    localparam logic [4:0] OP_LT   = 5'b10101;
    localparam logic [4:0] OP_MAX  = 5'b10110;
    localparam logic [4:0] OP_MIN  = 5'b10111;

    // Quotient reported for divide-by-zero
    localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

endpackage

// File: rtl/alu_8bit_comb.sv
// alu_8bit_comb
//   Purely combinational ALU function: result_o = f(cmd_i, a_i, b_i).
// Ports:
//   a_i, b_i  in  8   unsigned operands
//   cmd_i     in  5   opcode (see alu_8bit_pkg)
//   res_o     out 16  result; 8-bit results are zero-extended
module alu_8bit_comb
    import alu_8bit_pkg::*;
(
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    input  logic [4:0]  cmd_i,
    output logic [15:0] res_o
);

    logic [15:0] a16;
    logic [15:0] b16;
    logic [7:0]  neg_a;
    logic        b_zero;

    assign a16    = {8'h00, a_i};
    assign b16    = {8'h00, b_i};
    assign neg_a  = ~a_i + 8'd1;
    assign b_zero = (b_i == 8'h00);

    always_comb begin
        res_o = 16'h0000;
        case (cmd_i)
            OP_ADD:  res_o = a16 + b16;
            OP_SUB:  res_o = a16 - b16;          // wraps modulo 2^16
            OP_MUL:  res_o = a16 * b16;          // 255*255 fits in 16 bits
            OP_DIV:  res_o = b_zero ? DIV0_RESULT : a16 / b16;
            OP_MOD:  res_o = b_zero ? a16 : a16 % b16;
            OP_INC:  res_o = a16 + 16'd1;
            OP_DEC:  res_o = a16 - 16'd1;
            OP_AND:  res_o = {8'h00, a_i & b_i};
            OP_OR:   res_o = {8'h00, a_i | b_i};
            OP_XOR:  res_o = {8'h00, a_i ^ b_i};
            OP_NAND: res_o = {8'h00, ~(a_i & b_i)};
            OP_NOR:  res_o = {8'h00, ~(a_i | b_i)};
            OP_XNOR: res_o = {8'h00, ~(a_i ^ b_i)};
            OP_NOT:  res_o = {8'h00, ~a_i};
            OP_SHL:  res_o = {7'd0, a_i, 1'b0};  // bit 7 lands in res[8]
            OP_SHR:  res_o = {9'd0, a_i[7:1]};
            OP_ROL:  res_o = {8'h00, a_i[6:0], a_i[7]};
            OP_ROR:  res_o = {8'h00, a_i[0], a_i[7:1]};
            OP_NEG:  res_o = {8'h00, neg_a};
            OP_GT:   res_o = {15'd0, a_i > b_i};
            OP_EQ:   res_o = {15'd0, a_i == b_i};
            OP_LT:   res_o = {15'd0, a_i < b_i};
            OP_MAX:  res_o = {8'h00, (a_i > b_i) ? a_i : b_i};
            OP_MIN:  res_o = {8'h00, (a_i < b_i) ? a_i : b_i};
            default: res_o = 16'h0000;           // 11000..11111 undefined
        endcase
    end

endmodule

// File: rtl/alu_8bit.sv
// alu_8bit
//   Registered 8-bit ALU, one cycle latency. Captures the combinational
//   result when enable is high, otherwise holds y.
// Ports:
//   clk      in  1   rising-edge clock
//   rst      in  1   asynchronous active-high reset, clears y
//   a, b     in  8   unsigned operands
//   command  in  5   opcode
//   enable   in  1   1 = capture new result, 0 = hold
//   y        out 16  registered result
module alu_8bit
    import alu_8bit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [4:0]  command,
    input  logic        enable,
    output logic [15:0] y
);

    logic [15:0] res;
    logic [15:0] y_d;
    logic [15:0] y_q;

    alu_8bit_comb u_comb (
        .a_i   (a),
        .b_i   (b),
        .cmd_i (command),
        .res_o (res)
    );

    assign y_d = enable ? res : y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) y_q <= 16'h0000;
        else     y_q <= y_d;
    end

    assign y = y_q;

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit
//   Directed steps followed by random traffic, checked against an integer
//   reference model of the command map.
module tb_alu_8bit;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [4:0]  command;
    logic        enable;
    logic [15:0] y;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_y;

    alu_8bit dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .command (command),
        .enable  (enable),
        .y       (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic over the command map.
    function automatic logic [15:0] model(input logic [4:0] c, input logic [7:0] a8, input logic [7:0] b8);
        int x;
        int z;
        int r;
        x = int'(a8);
        z = int'(b8);
        r = 0;
        case (int'(c))
            0:  r = x + z;
            1:  r = x - z;
            2:  r = x * z;
            3:  r = (z == 0) ? 65535 : x / z;
            4:  r = (z == 0) ? x : x % z;
            5:  r = x + 1;
            6:  r = x - 1;
            7:  r = x & z;
            8:  r = x | z;
            9:  r = x ^ z;
            10: r = 255 - (x & z);
            11: r = 255 - (x | z);
            12: r = 255 - (x ^ z);
            13: r = 255 - x;
            14: r = x * 2;
            15: r = x / 2;
            16: r = (x * 2) % 256 + x / 128;
            17: r = x / 2 + (x % 2) * 128;
            18: r = (256 - x) % 256;
            19: r = (x > z) ? 1 : 0;
            20: r = (x == z) ? 1 : 0;
            21: r = (x < z) ? 1 : 0;
            22: r = (x > z) ? x : z;
            23: r = (x < z) ? x : z;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] expv);
        total++;
        assert (y === expv) else begin
            bad++;
            $error("FAIL %s: y=%h expected=%h", tag, y, expv);
        end
    endtask

    // Drive inputs, clock once, then compare against the model/hold value.
    task automatic step(input string tag, input logic [4:0] c, input logic [7:0] av,
                        input logic [7:0] bv, input logic en, input logic [15:0] fixed, input bit use_fixed);
        command = c; a = av; b = bv; enable = en;
        @(posedge clk); #1;
        if (en) exp_y = use_fixed ? fixed : model(c, av, bv);
        check(tag, exp_y);
    endtask

    initial begin
        rst = 1'b1; a = 8'd0; b = 8'd0; command = 5'd0; enable = 1'b0;
        exp_y = 16'h0000;
        #2;
        check("reset_async", 16'h0000);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Directed, with spec-derived constants
        step("add_15_10",   5'b00000, 8'd15,  8'd10,  1'b1, 16'd25,     1);
        step("mul_255_255", 5'b00010, 8'd255, 8'd255, 1'b1, 16'd65025,  1);
        step("sub_25_5",    5'b00001, 8'd25,  8'd5,   1'b1, 16'd20,     1);
        step("sub_5_10",    5'b00001, 8'd5,   8'd10,  1'b1, 16'hFFFB,   1);
        step("div_40_8",    5'b00011, 8'd40,  8'd8,   1'b1, 16'd5,      1);
        step("div_by_0",    5'b00011, 8'd7,   8'd0,   1'b1, 16'hFFFF,   1);
        step("mod_by_0",    5'b00100, 8'd7,   8'd0,   1'b1, 16'd7,      1);
        step("not_14",      5'b01101, 8'd14,  8'd99,  1'b1, 16'd241,    1);
        step("shl_81",      5'b01110, 8'h81,  8'd0,   1'b1, 16'h0102,   1);
        step("rol_81",      5'b10000, 8'h81,  8'd0,   1'b1, 16'h0003,   1);
        step("ror_81",      5'b10001, 8'h81,  8'd0,   1'b1, 16'h00C0,   1);
        step("shr_81",      5'b01111, 8'h81,  8'd0,   1'b1, 16'h0040,   1);
        step("neg_17",      5'b10010, 8'd17,  8'd0,   1'b1, 16'd239,    1);
        step("neg_0",       5'b10010, 8'd0,   8'd0,   1'b1, 16'd0,      1);
        step("inc_255",     5'b00101, 8'd255, 8'd0,   1'b1, 16'd256,    1);
        step("dec_0",       5'b00110, 8'd0,   8'd0,   1'b1, 16'hFFFF,   1);
        step("gt_21_69",    5'b10011, 8'd21,  8'd69,  1'b1, 16'd0,      1);
        step("lt_21_69",    5'b10101, 8'd21,  8'd69,  1'b1, 16'd1,      1);
        step("eq_9_9",      5'b10100, 8'd9,   8'd9,   1'b1, 16'd1,      1);
        step("max_27_20",   5'b10110, 8'd27,  8'd20,  1'b1, 16'd27,     1);
        step("min_31_10",   5'b10111, 8'd31,  8'd10,  1'b1, 16'd10,     1);
        step("xnor",        5'b01100, 8'hF0,  8'h3C,  1'b1, 16'h0033,   1);

        // Hold with enable low while inputs churn
        step("add_for_hold", 5'b00000, 8'd15, 8'd10,  1'b1, 16'd25,     1);
        step("hold_1",       5'b00010, 8'd200, 8'd3,  1'b0, 16'd0,      0);
        step("hold_2",       5'b01101, 8'd1,   8'd2,  1'b0, 16'd0,      0);
        step("hold_3",       5'b10110, 8'd77,  8'd9,  1'b0, 16'd0,      0);
        step("undef_11000",  5'b11000, 8'd5,   8'd6,  1'b1, 16'h0000,   1);
        step("undef_11111",  5'b11111, 8'hFF,  8'hFF, 1'b1, 16'h0000,   1);

        // Asynchronous reset between edges
        step("add_pre_rst",  5'b00000, 8'd15, 8'd10,  1'b1, 16'd25,     1);
        #2 rst = 1'b1;
        #1 check("rst_mid_cycle", 16'h0000);
        exp_y = 16'h0000;
        command = 5'b00010; a = 8'd100; b = 8'd100; enable = 1'b1;
        @(posedge clk); #1 check("rst_held_1", 16'h0000);
        @(posedge clk); #1 check("rst_held_2", 16'h0000);
        #3 rst = 1'b0;
        #1 check("rst_released", 16'h0000);
        step("first_after_rst", 5'b00010, 8'd100, 8'd100, 1'b1, 16'd10000, 1);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic [4:0] rc;
            logic [7:0] ra;
            logic [7:0] rb;
            logic       ren;
            rc  = 5'($urandom_range(0, 31));
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            if ($urandom_range(0, 7) == 0) rb = ra;
            ren = ($urandom_range(0, 3) != 0);
            step("random", rc, ra, rb, ren, 16'd0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
